// File: rtl/bank_htu_pkg.sv
// Shared types and helpers for the HTU bank victim controller.
// The lock feature is enabled with the BANK_HTU_LOCK_EN macro.
package bank_htu_pkg;

  localparam int NUM_WAYS  = 8;
  localparam int WAY_IDX_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PICK,
    ST_EVICT_REQ,
    ST_EVICT_WAIT,
    ST_RESP,
    ST_UPD
  } state_e;

  function automatic logic [NUM_WAYS-1:0] lowest_set(
    input logic [NUM_WAYS-1:0] v
  );
    return v & (~v + NUM_WAYS'(1));
  endfunction

  function automatic logic [WAY_IDX_W-1:0] onehot2idx(
    input logic [NUM_WAYS-1:0] v
  );
    logic [WAY_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (v[i]) idx = idx | WAY_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bank_htu_victim_pick.sv
// Combinational victim selection: free way, then PLRU oldest, then any
// unlocked way. none_o flags that every way is locked.
module bank_htu_victim_pick
  import bank_htu_pkg::*;
(
  input  logic [NUM_WAYS-1:0]  valid_i,
  input  logic [NUM_WAYS-1:0]  dirty_i,
  input  logic [NUM_WAYS-1:0]  lock_i,
  input  logic [NUM_WAYS-1:0]  oldest_i,
  output logic [WAY_IDX_W-1:0] victim_o,
  output logic                 dirty_o,
  output logic                 none_o
);

  logic [NUM_WAYS-1:0] unlocked;
  logic [NUM_WAYS-1:0] free;
  logic [NUM_WAYS-1:0] old_ok;
  logic [NUM_WAYS-1:0] sel;

  assign unlocked = ~lock_i;
  assign free     = ~valid_i & unlocked;
  assign old_ok   = oldest_i & unlocked;

  always_comb begin
    sel = '0;
    if (|free) begin
      sel = lowest_set(free);
    end else if (|old_ok) begin
      sel = lowest_set(old_ok);
    end else begin
      sel = lowest_set(unlocked);
    end
  end

  assign victim_o = onehot2idx(sel);
  assign dirty_o  = |(sel & valid_i & dirty_i);
  assign none_o   = ~|unlocked;

endmodule

// File: rtl/bank_htu_victim_ctrl.sv
// HTU bank allocation/replacement controller sharing one PLRU port.
// Define BANK_HTU_LOCK_EN to let way_lock_i mask victim candidates.
module bank_htu_victim_ctrl
  import bank_htu_pkg::WAY_IDX_W;
#(
  parameter int NUM_WAYS        = 8,
  parameter int FILL_STARVE_MAX = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 hit_vld_i,
  input  logic [NUM_WAYS-1:0]  hit_way_i,
  input  logic                 alloc_req_vld_i,
  output logic                 alloc_req_rdy_o,
  output logic                 alloc_rsp_vld_o,
  input  logic                 alloc_rsp_rdy_i,
  output logic [WAY_IDX_W-1:0] alloc_rsp_way_o,
  input  logic [NUM_WAYS-1:0]  way_valid_i,
  input  logic [NUM_WAYS-1:0]  way_dirty_i,
  input  logic [NUM_WAYS-1:0]  way_lock_i,
  output logic                 evict_vld_o,
  input  logic                 evict_rdy_i,
  output logic [WAY_IDX_W-1:0] evict_way_o,
  input  logic                 evict_done_i,
  output logic [NUM_WAYS-1:0]  plru_access_o,
  input  logic [NUM_WAYS-1:0]  plru_oldest_i,
  output logic                 busy_o
);

  import bank_htu_pkg::state_e;
  import bank_htu_pkg::ST_IDLE;
  import bank_htu_pkg::ST_PICK;
  import bank_htu_pkg::ST_EVICT_REQ;
  import bank_htu_pkg::ST_EVICT_WAIT;
  import bank_htu_pkg::ST_RESP;
  import bank_htu_pkg::ST_UPD;

  localparam logic [3:0] STARVE_MAX = 4'(FILL_STARVE_MAX);

  state_e               state_q;
  logic                 req_rdy_q;
  logic                 rsp_vld_q;
  logic                 evict_vld_q;
  logic                 busy_q;
  logic [WAY_IDX_W-1:0] victim_q;
  logic [3:0]           starve_q;

  logic [NUM_WAYS-1:0]  lock_m;
  logic [WAY_IDX_W-1:0] pick_way;
  logic                 pick_dirty;
  logic                 pick_none;
  logic                 hit_wins;
  logic                 fill_win;
  logic [NUM_WAYS-1:0]  victim_oh;
  logic [NUM_WAYS-1:0]  hit_oh;

`ifdef BANK_HTU_LOCK_EN
  assign lock_m = way_lock_i;
`else
  logic unused_lock;
  assign unused_lock = ^way_lock_i;
  assign lock_m      = '0;
`endif

  bank_htu_victim_pick u_pick (
    .valid_i  (way_valid_i),
    .dirty_i  (way_dirty_i),
    .lock_i   (lock_m),
    .oldest_i (plru_oldest_i),
    .victim_o (pick_way),
    .dirty_o  (pick_dirty),
    .none_o   (pick_none)
  );

  // A deferred fill eventually wins so the victim is not left as oldest.
  assign hit_wins  = hit_vld_i && (starve_q < STARVE_MAX);
  assign fill_win  = (state_q == ST_UPD) && !hit_wins;
  assign victim_oh = {{(NUM_WAYS-1){1'b0}}, 1'b1} << victim_q;
  assign hit_oh    = hit_way_i & (~hit_way_i + NUM_WAYS'(1));

  always_comb begin
    plru_access_o = '0;
    if (!rst_ni) begin
      plru_access_o = '0;
    end else if (fill_win) begin
      plru_access_o = victim_oh;
    end else if (hit_vld_i) begin
      plru_access_o = hit_oh;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      req_rdy_q   <= 1'b0;
      rsp_vld_q   <= 1'b0;
      evict_vld_q <= 1'b0;
      busy_q      <= 1'b0;
      victim_q    <= '0;
      starve_q    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (alloc_req_vld_i && req_rdy_q) begin
            state_q   <= ST_PICK;
            req_rdy_q <= 1'b0;
            busy_q    <= 1'b1;
          end else begin
            req_rdy_q <= 1'b1;
          end
        end
        ST_PICK: begin
          if (!pick_none) begin
            victim_q <= pick_way;
            if (pick_dirty) begin
              state_q     <= ST_EVICT_REQ;
              evict_vld_q <= 1'b1;
            end else begin
              state_q   <= ST_RESP;
              rsp_vld_q <= 1'b1;
            end
          end
        end
        ST_EVICT_REQ: begin
          if (evict_rdy_i) begin
            state_q     <= ST_EVICT_WAIT;
            evict_vld_q <= 1'b0;
          end
        end
        ST_EVICT_WAIT: begin
          if (evict_done_i) begin
            state_q   <= ST_RESP;
            rsp_vld_q <= 1'b1;
          end
        end
        ST_RESP: begin
          if (alloc_rsp_rdy_i) begin
            state_q   <= ST_UPD;
            rsp_vld_q <= 1'b0;
            starve_q  <= '0;
          end
        end
        ST_UPD: begin
          if (hit_wins) begin
            if (starve_q != 4'hF) starve_q <= starve_q + 4'd1;
          end else begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            req_rdy_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign alloc_req_rdy_o = req_rdy_q;
  assign alloc_rsp_vld_o = rsp_vld_q;
  assign alloc_rsp_way_o = victim_q;
  assign evict_vld_o     = evict_vld_q;
  assign evict_way_o     = victim_q;
  assign busy_o          = busy_q;

endmodule

// File: doc/bank_htu_victim_ctrl.md
# bank_htu_victim_ctrl

Allocation and replacement controller for the 8-way HTU bank. It arbitrates the single PLRU-tree access port between lookup-hit updates and miss allocations. For each allocation it selects a victim way from valid/lock state and the tree's oldest-way vector, and sequences eviction of a dirty victim before returning the way to the requester. It sits between the bank lookup pipeline, the allocation requester, the eviction engine and the external `bank_htu_plru_tree` instance.

## Interface
- `NUM_WAYS`, 8, number of ways; only 8 is legal.
- `FILL_STARVE_MAX`, 4, maximum cycles a pending fill update may be deferred by hits (range 1..15).

- `clk_i` in 1: clock.
- `rst_ni` in 1: reset. One clock; reset is synchronous and active-low.
- `hit_vld_i` in 1: lookup hit this cycle.
- `hit_way_i` in 8: one-hot hit way.
- `alloc_req_vld_i` in 1 / `alloc_req_rdy_o` out 1: allocation request handshake.
- `alloc_rsp_vld_o` out 1 / `alloc_rsp_rdy_i` in 1: allocation response handshake.
- `alloc_rsp_way_o` out 3: allocated way index.
- `way_valid_i` in 8: per-way valid.
- `way_dirty_i` in 8: per-way dirty.
- `way_lock_i` in 8: per-way lock (used only with `BANK_HTU_LOCK_EN`).
- `evict_vld_o` out 1 / `evict_rdy_i` in 1: eviction command handshake.
- `evict_way_o` out 3: way to evict.
- `evict_done_i` in 1: eviction writeback complete (single-cycle pulse).
- `plru_access_o` out 8: one-hot or zero access vector to the PLRU tree.
- `plru_oldest_i` in 8: one-hot oldest way from the PLRU tree.
- `busy_o` out 1: FSM not in IDLE.

## Operation
- States: IDLE, PICK, EVICT_REQ, EVICT_WAIT, RESP, UPD.
- IDLE: `alloc_req_rdy_o`=1. On `vld & rdy`, go to PICK.
- PICK: select victim in this priority order:
  - lowest-index way with valid=0 and unlocked;
  - otherwise the `plru_oldest_i` way, if unlocked;
  - otherwise the lowest-index unlocked way.
  - If all ways are locked, remain in PICK and re-evaluate every cycle.
  - The victim is registered. Victim valid&dirty goes to EVICT_REQ; otherwise go to RESP.
- EVICT_REQ: `evict_vld_o`=1, `evict_way_o`=victim, held stable until `evict_rdy_i`, then go to EVICT_WAIT. `evict_done_i` is ignored in this state.
- EVICT_WAIT: on `evict_done_i`, go to RESP.
- RESP: `alloc_rsp_vld_o`=1, `alloc_rsp_way_o`=victim, held stable until `alloc_rsp_rdy_i`, then go to UPD.
- UPD: issue a fill update (`plru_access_o`=onehot(victim)), then go to IDLE.
  - A hit in the same cycle wins while `starve_cnt < FILL_STARVE_MAX`.
  - Otherwise the fill wins and that cycle's hit update is dropped.
  - `starve_cnt` clears on UPD entry and increments on each deferral (4 bits, saturating).
- PLRU port outside a winning fill: `plru_access_o` = lowest set bit of `hit_way_i` when `hit_vld_i`, else 0. The output is never multi-hot.
- Hits are serviced in every state. Valid/dirty/lock are sampled only in PICK.

## Timing
- Reset values: `alloc_req_rdy_o`=0, `alloc_rsp_vld_o`=0, `alloc_rsp_way_o`=0, `evict_vld_o`=0, `evict_way_o`=0, `plru_access_o`=0, `busy_o`=0, state=IDLE, `starve_cnt`=0. `alloc_req_rdy_o` rises the first cycle after reset release.
- `plru_access_o` is combinational from `hit_*` and state, so the tree registers the update at the same edge.
- Minimum clean allocation: request accepted cycle 0, PICK cycle 1, `rsp_vld` cycle 2. With `rsp_rdy`=1 the fill update is in cycle 3 and `req_rdy` returns in cycle 4.
- Dirty victim: `evict_vld` at cycle 2. `rsp_vld` comes one cycle after the `evict_done_i` pulse.
- Only one allocation is in flight at a time. `alloc_req_rdy_o`=0 outside IDLE.
- Reset asserted in any state aborts the allocation and drops `evict_vld_o` / `alloc_rsp_vld_o` at the next edge. The eviction engine shares the reset.

## Configuration
- `BANK_HTU_LOCK_EN`:
  - Defined: `way_lock_i` masks victim candidates as described, including the stall in PICK.
  - Undefined: `way_lock_i` is ignored (all ways treated unlocked) and PICK is always exactly one cycle.

## Structure
- Package `bank_htu_pkg` holds:
  - the state enum;
  - `NUM_WAYS` and `WAY_IDX_W`=3;
  - `onehot2idx` and `lowest_set` functions.
- Sub-module `bank_htu_victim_pick` is combinational. Inputs: valid, dirty, lock, oldest. Outputs: victim index, victim dirty, none_available.

## Test plan
- Way 3 invalid, others valid; allocate -> way 3, no eviction, `rsp_vld` at cycle 2, `plru_access_o`=8'h08 at cycle 3.
- All valid, `plru_oldest_i`=8'h20, way 5 clean -> `rsp_way`=5, no `evict_vld`.
- All valid and dirty, oldest=8'h01, `evict_rdy` delayed 3 cycles, done 5 cycles later -> `evict_way`=0 held stable, `rsp_vld` one cycle after done.
- Continuous `hit_way_i`=8'h80 during UPD with `FILL_STARVE_MAX`=4 -> hits win for 4 cycles, fill wins on the 5th, then back to IDLE.
- (LOCK_EN) All locked for 6 cycles, then way 6 unlocked with all valid and oldest=8'h02 (way 1 locked) -> PICK stalls 6 cycles, then victim is way 6.
- Reset asserted during EVICT_WAIT -> all outputs at reset values next cycle; a new request completes normally.
